bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/timer_pkg.sv | 19 +
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/bcd_countdown_timer.sv | 128 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state type,
// BCD digit limits and the preset clamping helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit register: synchronous load, decrement on enable with
// wrap to a configurable value, and a borrow-out for the next digit.
module bcd_digit_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic [3:0] wrap,
  output logic [3:0] q,
  output logic       borrow
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (ld)
      q <= ld_val;
    else if (en)
      q <= (q == '0) ? wrap : q - 4'd1;
  end

  assign borrow = en && (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with start/pause control, one-second prescaler,
// expiry alarm and optional auto-reload of the stored preset.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIV     = 100000000,
  parameter int unsigned M10_MAX = 9
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       load,
  input  logic       go,
  input  logic       auto_reload,
  input  logic [3:0] PM10,
  input  logic [3:0] PM1,
  input  logic [3:0] PS10,
  input  logic [3:0] PS1,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [3:0] s10,
  output logic [3:0] s1,
  output logic       zero,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0] M10_LIM = 4'(M10_MAX);

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   preset;
  logic [15:0]   clamped;
  logic [15:0]   ld_digits;
  logic          tick;
  logic          expiring;
  logic          reload;
  logic          digit_ld;
  logic          b_s1, b_s10, b_m1, b_m10;

  assign clamped = {clamp_digit(PM10, M10_LIM), clamp_digit(PM1, BCD_MAX),
                    clamp_digit(PS10, SEC_TENS_MAX), clamp_digit(PS1, BCD_MAX)};

  assign tick     = (state == RUN) && (presc == PRESC_LAST);
  // Count is 00:01, so this tick lands on 00:00.
  assign expiring = (m10 == '0) && (m1 == '0) && (s10 == '0) && (s1 == 4'd1);
  assign reload   = tick && expiring && auto_reload && !load;

  assign digit_ld  = load || reload;
  assign ld_digits = load ? clamped : preset;

  bcd_digit_dec u_s1 (
    .clk(CLK100MHZ), .rst(rst), .ld(digit_ld), .ld_val(ld_digits[3:0]),
    .en(tick), .wrap(BCD_MAX), .q(s1), .borrow(b_s1)
  );

  bcd_digit_dec u_s10 (
    .clk(CLK100MHZ), .rst(rst), .ld(digit_ld), .ld_val(ld_digits[7:4]),
    .en(b_s1), .wrap(SEC_TENS_MAX), .q(s10), .borrow(b_s10)
  );

  bcd_digit_dec u_m1 (
    .clk(CLK100MHZ), .rst(rst), .ld(digit_ld), .ld_val(ld_digits[11:8]),
    .en(b_s10), .wrap(BCD_MAX), .q(m1), .borrow(b_m1)
  );

  bcd_digit_dec u_m10 (
    .clk(CLK100MHZ), .rst(rst), .ld(digit_ld), .ld_val(ld_digits[15:12]),
    .en(b_m1), .wrap(M10_LIM), .q(m10), .borrow(b_m10)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      preset <= '0;
      alarm  <= 1'b0;
    end else if (load) begin
      state  <= IDLE;
      presc  <= '0;
      preset <= clamped;
      alarm  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          alarm <= 1'b0;
          if (go && !zero) begin
            state <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          alarm <= 1'b0;
          presc <= tick ? '0 : presc + 1'b1;
          if (go)
            state <= PAUSE;
          // Expiry without reload overrides a coincident pause request.
          if (tick && expiring) begin
            alarm <= 1'b1;
            if (!auto_reload)
              state <= DONE;
          end
        end
        PAUSE: begin
          alarm <= 1'b0;
          if (go)
            state <= RUN;
        end
        DONE: begin
          alarm <= 1'b1;
          if (go) begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero    = (m10 == '0) && (m1 == '0) && (s10 == '0) && (s1 == '0);
  assign running = (state == RUN);

  logic unused_borrow;
  assign unused_borrow = b_m10;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a seconds-based reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_bcd_countdown_timer;

  localparam int DIV  = 4;
  localparam int M10M = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0, load = 1'b0, go = 1'b0, auto_reload = 1'b0;
  logic [3:0] PM10 = '0, PM1 = '0, PS10 = '0, PS1 = '0;
  logic [3:0] m10, m1, s10, s1;
  logic       zero, running, alarm;

  bcd_countdown_timer #(.DIV(DIV), .M10_MAX(M10M)) dut (
    .CLK100MHZ(clk), .rst(rst), .load(load), .go(go), .auto_reload(auto_reload),
    .PM10(PM10), .PM1(PM1), .PS10(PS10), .PS1(PS1),
    .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .zero(zero), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  logic [18:0] expq[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Reference model: count kept as plain seconds, mode as an int.
  int secs = 0, pre_secs = 0, mode = 0, phase = 0;
  bit m_alarm = 0;

  function automatic int lim(input int d, input int mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [18:0] predict();
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            secs == 0, mode == 1, m_alarm};
  endfunction

  task automatic model_step(input bit r, input bit ld, input bit g, input bit ar,
                            input int a, input int b, input int c, input int d);
    bit tk;
    if (r) begin
      secs = 0; pre_secs = 0; mode = 0; phase = 0; m_alarm = 0;
    end else if (ld) begin
      pre_secs = (lim(a, M10M) * 10 + lim(b, 9)) * 60 + lim(c, 5) * 10 + lim(d, 9);
      secs = pre_secs; mode = 0; phase = 0; m_alarm = 0;
    end else begin
      case (mode)
        0: begin
          m_alarm = 0;
          if (g && secs != 0) begin mode = 1; phase = 0; end
        end
        1: begin
          m_alarm = 0;
          tk = (phase == DIV - 1);
          phase = tk ? 0 : phase + 1;
          if (g) mode = 2;
          if (tk) begin
            secs = secs - 1;
            if (secs == 0) begin
              m_alarm = 1;
              if (ar) secs = pre_secs;
              else mode = 3;
            end
          end
        end
        2: begin
          m_alarm = 0;
          if (g) mode = 1;
        end
        default: begin
          m_alarm = 1;
          if (g) begin mode = 0; m_alarm = 0; end
        end
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input bit g, input bit ar,
                     input int a, input int b, input int c, input int d);
    @(negedge clk);
    rst = r; load = ld; go = g; auto_reload = ar;
    PM10 = 4'(a); PM1 = 4'(b); PS10 = 4'(c); PS1 = 4'(d);
    model_step(r, ld, g, ar, a, b, c, d);
    expq.push_back(predict());
  endtask

  task automatic idle(input int n, input bit ar);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, ar, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    logic [18:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {m10, m1, s10, s1, zero, running, alarm};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle%0d outputs {m10,m1,s10,s1,zero,running,alarm}: got %h_%h_%h_%h_%b%b%b expected %h_%h_%h_%h_%b%b%b",
                   cycle, a[18:15], a[14:11], a[10:7], a[6:3], a[2], a[1], a[0],
                   e[18:15], e[14:11], e[10:7], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int r, mn;
    bit ar;
    // Reset state, then expiry of 01:02.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 2);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(252, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    // Borrow chain 10:00 -> 09:59.
    cyc(0, 1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(5, 0);
    // Pause after 2 cycles, hold 10, resume.
    cyc(0, 1, 0, 0, 0, 0, 3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(10, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(6, 0);
    // Auto-reload of 00:02.
    cyc(0, 1, 0, 1, 0, 0, 0, 2);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    idle(12, 1);
    // Clamp with load+go together, including an over-limit minutes-tens.
    cyc(0, 1, 1, 0, 8, 12, 7, 3);
    idle(2, 0);
    cyc(0, 1, 1, 0, 3, 4, 15, 11);
    idle(2, 0);
    // Reset while running at 05:30.
    cyc(0, 1, 0, 0, 0, 5, 3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(2, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    // Go on a tick edge: decrement then pause.
    cyc(0, 1, 0, 0, 0, 0, 2, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(3, 0);
    // Randomised traffic with short presets so expiry happens often.
    ar = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 199) == 0) ar = ~ar;
      mn = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (r < 3)
        cyc(1, 0, 0, ar, 0, 0, 0, 0);
      else if (r < 25)
        cyc(0, 1, $urandom_range(0, 3) == 0, ar,
            mn ? $urandom_range(0, 15) : 0, mn ? $urandom_range(0, 15) : 0,
            $urandom_range(0, 1) + (mn ? $urandom_range(0, 6) : 0), $urandom_range(0, 15));
      else if (r < 80)
        cyc(0, 0, 1, ar, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
      else
        cyc(0, 0, 0, ar, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
